// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: DEPTH-entry memory plus a first-word-fall-through output register.
// Optional UART_TX_FIFO_DROP_CNT_EN adds o_drop_count, a saturating count of rejected writes.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_en,
    input  logic                  i_clr_ovf,
    input  logic                  i_next,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_ready,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
`ifdef UART_TX_FIFO_DROP_CNT_EN
    output logic                  o_overflow,
    output logic [7:0]            o_drop_count
`else
    output logic                  o_overflow
`endif
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  next_q;
    logic                  wr_acc;
    logic                  wr_rej;
    logic                  pop;
    logic                  load;
    logic                  ready_nxt;

    // Handshake: o_ready means o_data holds a byte for uart_tx; the byte is retired
    // on a rising edge of i_next seen while o_ready and i_en are both high.
    always_comb begin
        wr_acc    = i_wr_en && !o_full;
        wr_rej    = i_wr_en && o_full;
        pop       = i_en && o_ready && i_next && !next_q;
        load      = i_en && (!o_ready || pop) && (count != '0);
        ready_nxt = o_ready;
        count_nxt = count;
        if (load)
            ready_nxt = 1'b1;
        else if (pop)
            ready_nxt = 1'b0;
        if (wr_acc && !load)
            count_nxt = count + (ADDR_WIDTH+1)'(1);
        else if (!wr_acc && load)
            count_nxt = count - (ADDR_WIDTH+1)'(1);
    end

    // Storage is not reset; only occupancy tracking is.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_acc)
            mem[wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_data     <= '0;
            o_ready    <= 1'b0;
            o_full     <= 1'b0;
            o_empty    <= 1'b1;
            o_overflow <= 1'b0;
            next_q     <= 1'b0;
        end else begin
            next_q  <= i_next;
            count   <= count_nxt;
            o_ready <= ready_nxt;
            o_full  <= (count_nxt == FULL_CNT);
            o_empty <= (count_nxt == '0) && !ready_nxt;
            if (wr_acc)
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (load) begin
                o_data <= mem[rd_ptr];
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (wr_rej)
                o_overflow <= 1'b1;
            else if (i_clr_ovf)
                o_overflow <= 1'b0;
        end
    end

    assign o_count = count;

`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // A clear coinciding with a rejected write leaves that rejection counted.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            drop_cnt <= '0;
        else if (wr_rej && i_clr_ovf)
            drop_cnt <= 8'd1;
        else if (wr_rej && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
        else if (i_clr_ovf)
            drop_cnt <= '0;
    end

    assign o_drop_count = drop_cnt;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model compared every cycle,
// plus directed checks with literal expectations. Define UART_TX_FIFO_DROP_CNT_EN for the drop counter.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       clr_ovf;
    logic       nxt;
    logic [7:0] o_data;
    logic       o_ready;
    logic [4:0] o_count;
    logic       o_full;
    logic       o_empty;
    logic       o_overflow;
`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [7:0] o_drop_count;
`endif

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_wr_data    (wr_data),
        .i_wr_en      (wr_en),
        .i_clr_ovf    (clr_ovf),
        .i_next       (nxt),
        .o_data       (o_data),
        .o_ready      (o_ready),
        .o_count      (o_count),
        .o_full       (o_full),
        .o_empty      (o_empty),
`ifdef UART_TX_FIFO_DROP_CNT_EN
        .o_overflow   (o_overflow),
        .o_drop_count (o_drop_count)
`else
        .o_overflow   (o_overflow)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes in memory as a queue, plus the presented byte.
    logic [7:0] m_q[$];
    logic [7:0] pop_log[$];
    logic [7:0] m_data;
    logic       m_ready;
    logic       m_ovf;
    logic       m_next_q;
    logic       started = 1'b0;
    int         m_drop;
    bit         acc, rej, m_pop, m_load;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_data   = 8'h00;
            m_ready  = 1'b0;
            m_ovf    = 1'b0;
            m_next_q = 1'b0;
            m_drop   = 0;
            started  = 1'b1;
        end else if (started) begin
            acc    = wr_en && (m_q.size() < 16);
            rej    = wr_en && (m_q.size() == 16);
            m_pop  = en && m_ready && nxt && !m_next_q;
            m_load = en && (!m_ready || m_pop) && (m_q.size() != 0);
            if (m_pop)
                pop_log.push_back(m_data);
            if (m_load) begin
                m_data  = m_q.pop_front();
                m_ready = 1'b1;
            end else if (m_pop) begin
                m_ready = 1'b0;
            end
            if (acc)
                m_q.push_back(wr_data);
            if (rej)
                m_ovf = 1'b1;
            else if (clr_ovf)
                m_ovf = 1'b0;
            if (rej)
                m_drop = clr_ovf ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            else if (clr_ovf)
                m_drop = 0;
            m_next_q = nxt;
        end
    end

    logic       in_stream = 1'b0;
    logic [4:0] max_cnt   = '0;

    always @(negedge clk) begin
        if (started) begin
            check("o_data",     32'(o_data),     32'(m_data));
            check("o_ready",    32'(o_ready),    32'(m_ready));
            check("o_count",    32'(o_count),    32'(m_q.size()));
            check("o_full",     32'(o_full),     32'(m_q.size() == 16));
            check("o_empty",    32'(o_empty),    32'(m_q.size() == 0 && !m_ready));
            check("o_overflow", 32'(o_overflow), 32'(m_ovf));
`ifdef UART_TX_FIFO_DROP_CNT_EN
            check("o_drop_count", 32'(o_drop_count), 32'(m_drop));
`endif
            if (in_stream && o_count > max_cnt)
                max_cnt = o_count;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_next();
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; wr_data = 8'h00; wr_en = 1'b0; clr_ovf = 1'b0; nxt = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(o_ready), 32'h0);
        check("rst_empty", 32'(o_empty), 32'h1);
        check("rst_count", 32'(o_count), 32'h0);
        check("rst_data",  32'(o_data),  32'h0);

        // Single byte latency
        write_byte(8'h41);
        tick();
        check("lat_ready", 32'(o_ready), 32'h1);
        check("lat_data",  32'(o_data),  32'h41);
        check("lat_count", 32'(o_count), 32'h0);
        check("lat_empty", 32'(o_empty), 32'h0);
        pulse_next();
        check("lat_drained", 32'(o_empty), 32'h1);

        // Fill to DEPTH+1, overflow, then drain in order
        do_reset();
        wr_en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("fill_data", 32'(o_data),     32'h01);
        check("fill_count", 32'(o_count),   32'd16);
        check("fill_full", 32'(o_full),     32'h1);
        check("fill_ovf",  32'(o_overflow), 32'h0);
        write_byte(8'hFF);
        check("ovf_set",   32'(o_overflow), 32'h1);
        check("ovf_count", 32'(o_count),    32'd16);
        clr_ovf = 1'b1;
        write_byte(8'hEE);
        check("ovf_set_wins", 32'(o_overflow), 32'h1);
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(o_overflow), 32'h0);
        for (int k = 2; k <= 17; k++) begin
            nxt = 1'b1;
            tick();
            check("drain_order", 32'(o_data), 32'(k));
            nxt = 1'b0;
            tick();
        end
        nxt = 1'b1;
        tick();
        check("drain_last_ready", 32'(o_ready), 32'h0);
        check("drain_last_data",  32'(o_data),  32'h11);
        nxt = 1'b0;
        tick();

        // Level-held i_next pops exactly once
        do_reset();
        write_byte(8'h31);
        write_byte(8'h32);
        write_byte(8'h33);
        tick();
        nxt = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("hold_data",  32'(o_data),  32'h32);
        check("hold_count", 32'(o_count), 32'h1);
        nxt = 1'b0;
        tick();
        nxt = 1'b1;
        tick();
        check("rearm_data", 32'(o_data), 32'h33);
        nxt = 1'b0;
        tick();

        // Streaming across pointer wrap
        do_reset();
        pop_log.delete();
        in_stream = 1'b1;
        max_cnt   = '0;
        for (int i = 0; i < 40; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h80 + i);
            nxt     = 1'b1;
            tick();
            wr_en   = 1'b0;
            nxt     = 1'b0;
            tick();
        end
        pulse_next();
        in_stream = 1'b0;
        check("stream_max_count", 32'(max_cnt), 32'h1);
        check("stream_pops", 32'(pop_log.size()), 32'd40);
        for (int i = 0; i < 40 && i < pop_log.size(); i++)
            check("stream_order", 32'(pop_log[i]), 32'(8'h80 + i));

        // Output side disabled
        do_reset();
        write_byte(8'h5A);
        write_byte(8'hA5);
        tick();
        en = 1'b0;
        pulse_next();
        check("dis_data", 32'(o_data), 32'h5A);
        en = 1'b1;
        nxt = 1'b1;
        tick();
        check("en_data", 32'(o_data), 32'hA5);
        nxt = 1'b0;
        tick();

        // Reset while a byte is presented
        check("pre_rst_ready", 32'(o_ready), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", 32'(o_ready),    32'h0);
        check("midrst_data",  32'(o_data),     32'h0);
        check("midrst_empty", 32'(o_empty),    32'h1);
        check("midrst_full",  32'(o_full),     32'h0);
        check("midrst_count", 32'(o_count),    32'h0);
        check("midrst_ovf",   32'(o_overflow), 32'h0);

`ifdef UART_TX_FIFO_DROP_CNT_EN
        wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(i);
            tick();
        end
        wr_data = 8'hCC;
        for (int i = 0; i < 300; i++) tick();
        wr_en = 1'b0;
        check("drop_sat", 32'(o_drop_count), 32'd255);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("drop_clr", 32'(o_drop_count), 32'd0);
        check("drop_ovf_clr", 32'(o_overflow), 32'h0);
        clr_ovf = 1'b1;
        write_byte(8'hCC);
        clr_ovf = 1'b0;
        check("drop_clr_and_rej", 32'(o_drop_count), 32'd1);
        tick();
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
